// File: rtl/nv_nvdla_cacc_csb_arb.sv
// -----------------------------------------------------------------------------
// nv_nvdla_cacc_csb_arb
// Two-master CSB arbiter in front of the cacc register port.
//  - m0 (host) and m1 (auxiliary) requests are arbitrated round-robin onto
//    the single arb2cacc request port with zero added latency. A grant that
//    is stalled by arb2cacc_req_prdy=0 stays locked until it completes.
//  - Every accepted request that expects a response (a read, or a
//    non-posted write) records its owner in a small FIFO. Responses pop
//    the FIFO and are steered combinationally to that owner.
//  - A Q-channel (qreqn/qacceptn/qdeny) lets a power controller quiesce
//    the port. Outstanding responses are drained first, and the request
//    is denied if the drain does not finish within DRAIN_TMO cycles.
// Ports:
//  nvdla_core_clk, nvdla_core_rst    clock, async active-high reset
//  m0_req_*, m1_req_*                master request ports (pvld/prdy/pd)
//  arb2cacc_req_*                    shared request port towards cacc
//  cacc2arb_resp_*                   response from cacc
//  m0_resp_*, m1_resp_*              responses routed to each master
//  qreqn, qacceptn, qdeny            Q-channel
//  spurious_resp_err                 sticky: response arrived with no owner
// -----------------------------------------------------------------------------
module nv_nvdla_cacc_csb_arb #(
  parameter int OWN_DEPTH = 4,
  parameter int DRAIN_TMO = 64
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        m0_req_pvld,
  output logic        m0_req_prdy,
  input  logic [62:0] m0_req_pd,
  input  logic        m1_req_pvld,
  output logic        m1_req_prdy,
  input  logic [62:0] m1_req_pd,
  output logic        arb2cacc_req_pvld,
  input  logic        arb2cacc_req_prdy,
  output logic [62:0] arb2cacc_req_pd,
  input  logic        cacc2arb_resp_valid,
  input  logic [33:0] cacc2arb_resp_pd,
  output logic        m0_resp_valid,
  output logic [33:0] m0_resp_pd,
  output logic        m1_resp_valid,
  output logic [33:0] m1_resp_pd,
  input  logic        qreqn,
  output logic        qacceptn,
  output logic        qdeny,
  output logic        spurious_resp_err
);

  localparam int PW = (OWN_DEPTH > 1) ? $clog2(OWN_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(OWN_DEPTH);
  localparam logic [7:0]    TMO_LAST_C = 8'(DRAIN_TMO - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DENY  = 2'd3
  } q_state_e;

  // A read (bit54=0) or a non-posted write (bit55=1) produces a response.
  function automatic logic expects_resp(input logic [62:0] pd);
    return (~pd[54]) | pd[55];
  endfunction

  q_state_e      state_q, state_d;
  logic          qacceptn_q, qacceptn_d;
  logic          qdeny_q, qdeny_d;
  logic [7:0]    drain_cnt_q, drain_cnt_d;
  logic          lock_q, lock_d;
  logic          sel_q, sel_d;              // 0 = m0, 1 = m1
  logic          last_grant_q, last_grant_d;
  logic          spur_q, spur_d;
  logic          own_q [OWN_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          elig0_s, elig1_s, full_s;
  logic          gnt_vld_s, gnt_sel_s;
  logic          sel_pvld_s, req_pvld_s, hs_s, push_s, pop_s, head_s;
  logic [62:0]   sel_pd_s;

  // Eligibility and round-robin / locked grant selection.
  always_comb begin
    full_s    = (cnt_q == DEPTH_C);
    elig0_s   = m0_req_pvld & (state_q == ST_RUN) & ((~full_s) | (~expects_resp(m0_req_pd)));
    elig1_s   = m1_req_pvld & (state_q == ST_RUN) & ((~full_s) | (~expects_resp(m1_req_pd)));
    gnt_vld_s = 1'b0;
    gnt_sel_s = sel_q;
    if (lock_q) begin
      gnt_vld_s = 1'b1;
      gnt_sel_s = sel_q;
    end else if (elig0_s && elig1_s) begin
      // last_grant=1 means m1 went last, so m0 wins, and vice versa.
      gnt_vld_s = 1'b1;
      gnt_sel_s = ~last_grant_q;
    end else if (elig0_s) begin
      gnt_vld_s = 1'b1;
      gnt_sel_s = 1'b0;
    end else if (elig1_s) begin
      gnt_vld_s = 1'b1;
      gnt_sel_s = 1'b1;
    end else begin
      gnt_vld_s = 1'b0;
      gnt_sel_s = sel_q;
    end
  end

  assign sel_pvld_s = gnt_sel_s ? m1_req_pvld : m0_req_pvld;
  assign sel_pd_s   = gnt_sel_s ? m1_req_pd   : m0_req_pd;
  assign req_pvld_s = gnt_vld_s & sel_pvld_s;
  assign hs_s       = req_pvld_s & arb2cacc_req_prdy;
  assign push_s     = hs_s & expects_resp(sel_pd_s);
  assign pop_s      = cacc2arb_resp_valid & (cnt_q != '0);
  assign head_s     = own_q[rd_ptr_q];

  assign arb2cacc_req_pvld = req_pvld_s;
  assign arb2cacc_req_pd   = req_pvld_s ? sel_pd_s : 63'd0;
  assign m0_req_prdy       = req_pvld_s & (~gnt_sel_s) & arb2cacc_req_prdy;
  assign m1_req_prdy       = req_pvld_s & gnt_sel_s & arb2cacc_req_prdy;

  assign m0_resp_valid     = pop_s & (~head_s);
  assign m1_resp_valid     = pop_s & head_s;
  assign m0_resp_pd        = (pop_s && !head_s) ? cacc2arb_resp_pd : 34'd0;
  assign m1_resp_pd        = (pop_s && head_s)  ? cacc2arb_resp_pd : 34'd0;

  assign qacceptn          = qacceptn_q;
  assign qdeny             = qdeny_q;
  assign spurious_resp_err = spur_q;

  // Next values for grant lock, pointers, owner count and error flag.
  always_comb begin
    lock_d       = req_pvld_s & (~arb2cacc_req_prdy);
    sel_d        = req_pvld_s ? gnt_sel_s : sel_q;
    last_grant_d = hs_s ? gnt_sel_s : last_grant_q;
    spur_d       = spur_q | (cacc2arb_resp_valid & (cnt_q == '0));
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Arbiter and owner-FIFO registers.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      lock_q       <= 1'b0;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      spur_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < OWN_DEPTH; i++) own_q[i] <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      spur_q       <= spur_d;
      cnt_q        <= cnt_d;
      if (push_s) begin
        own_q[wr_ptr_q] <= gnt_sel_s;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Q-channel state register with registered qacceptn/qdeny decodes.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q     <= ST_STOP;
      drain_cnt_q <= 8'd0;
      qacceptn_q  <= 1'b0;
      qdeny_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      qacceptn_q  <= qacceptn_d;
      qdeny_q     <= qdeny_d;
    end
  end

  // Q-channel next state. RUN waits for lock_d so a request presented but
  // not yet accepted this cycle is never abandoned mid-handshake.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_STOP: begin
        if (qreqn) state_d = ST_RUN;
        else       state_d = ST_STOP;
      end
      ST_RUN: begin
        if (!qreqn && !lock_d) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 8'd0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (qreqn) begin
          state_d = ST_RUN;
        end else if (cnt_d == '0) begin
          state_d = ST_STOP;
        end else if (drain_cnt_q == TMO_LAST_C) begin
          state_d = ST_DENY;
        end else begin
          state_d     = ST_DRAIN;
          drain_cnt_d = drain_cnt_q + 8'd1;
        end
      end
      ST_DENY: begin
        if (qreqn) state_d = ST_RUN;
        else       state_d = ST_DENY;
      end
      default: state_d = ST_STOP;
    endcase
  end

  // Q-channel output decodes of the next state.
  always_comb begin
    qacceptn_d = (state_d != ST_STOP);
    qdeny_d    = (state_d == ST_DENY);
  end

endmodule

// File: tb/tb_nv_nvdla_cacc_csb_arb.sv
module tb_nv_nvdla_cacc_csb_arb;

  localparam logic        H    = 1'b1;
  localparam logic        L    = 1'b0;
  localparam logic [62:0] NOPD = 63'd0;
  localparam logic [33:0] NORS = 34'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req_pvld = 1'b0, m1_req_pvld = 1'b0;
  logic        m0_req_prdy, m1_req_prdy;
  logic [62:0] m0_req_pd = 63'd0, m1_req_pd = 63'd0;
  logic        arb2cacc_req_pvld;
  logic        arb2cacc_req_prdy = 1'b0;
  logic [62:0] arb2cacc_req_pd;
  logic        cacc2arb_resp_valid = 1'b0;
  logic [33:0] cacc2arb_resp_pd = 34'd0;
  logic        m0_resp_valid, m1_resp_valid;
  logic [33:0] m0_resp_pd, m1_resp_pd;
  logic        qreqn = 1'b0;
  logic        qacceptn, qdeny, spurious_resp_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nv_nvdla_cacc_csb_arb #(.OWN_DEPTH(4), .DRAIN_TMO(8)) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rst      (rst),
    .m0_req_pvld         (m0_req_pvld),
    .m0_req_prdy         (m0_req_prdy),
    .m0_req_pd           (m0_req_pd),
    .m1_req_pvld         (m1_req_pvld),
    .m1_req_prdy         (m1_req_prdy),
    .m1_req_pd           (m1_req_pd),
    .arb2cacc_req_pvld   (arb2cacc_req_pvld),
    .arb2cacc_req_prdy   (arb2cacc_req_prdy),
    .arb2cacc_req_pd     (arb2cacc_req_pd),
    .cacc2arb_resp_valid (cacc2arb_resp_valid),
    .cacc2arb_resp_pd    (cacc2arb_resp_pd),
    .m0_resp_valid       (m0_resp_valid),
    .m0_resp_pd          (m0_resp_pd),
    .m1_resp_valid       (m1_resp_valid),
    .m1_resp_pd          (m1_resp_pd),
    .qreqn               (qreqn),
    .qacceptn            (qacceptn),
    .qdeny               (qdeny),
    .spurious_resp_err   (spurious_resp_err)
  );

  typedef struct {
    logic        m0v;
    logic [62:0] m0pd;
    logic        m1v;
    logic [62:0] m1pd;
    logic        crdy;
    logic        rv;
    logic [33:0] rpd;
    logic        qn;
    logic        m0r;
    logic        m1r;
    logic        cv;
    logic [62:0] cpd;
    logic        r0v;
    logic        r1v;
    logic        qa;
    logic        qd;
    logic        se;
  } vec_t;

  vec_t tv[$];

  // read: bits 54/55 clear; posted write: bit54 set, bit55 clear
  function automatic logic [62:0] rd(input int k);
    return 63'h100 + 63'(k);
  endfunction
  function automatic logic [62:0] pw(input int k);
    return 63'h0040_0000_0000_0200 + 63'(k);
  endfunction
  function automatic logic [33:0] rp(input int k);
    return 34'h1000 + 34'(k);
  endfunction

  function automatic vec_t mk(input logic m0v, input logic [62:0] m0pd, input logic m1v,
                              input logic [62:0] m1pd, input logic crdy, input logic rv,
                              input logic [33:0] rpd, input logic qn, input logic m0r,
                              input logic m1r, input logic cv, input logic [62:0] cpd,
                              input logic r0v, input logic r1v, input logic qa,
                              input logic qd, input logic se);
    vec_t v;
    v.m0v = m0v; v.m0pd = m0pd; v.m1v = m1v; v.m1pd = m1pd; v.crdy = crdy;
    v.rv = rv; v.rpd = rpd; v.qn = qn; v.m0r = m0r; v.m1r = m1r; v.cv = cv;
    v.cpd = cpd; v.r0v = r0v; v.r1v = r1v; v.qa = qa; v.qd = qd; v.se = se;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset: outputs quiet even with requests and qreqn driven
    #1;
    rst = 1'b1;
    m0_req_pvld = 1'b1; m0_req_pd = rd(0);
    m1_req_pvld = 1'b1; m1_req_pd = rd(1);
    arb2cacc_req_prdy = 1'b1;
    qreqn = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    chk("rst m0_prdy", 64'(m0_req_prdy), 64'(L));
    chk("rst m1_prdy", 64'(m1_req_prdy), 64'(L));
    chk("rst cacc_pvld", 64'(arb2cacc_req_pvld), 64'(L));
    chk("rst qacceptn", 64'(qacceptn), 64'(L));
    chk("rst qdeny", 64'(qdeny), 64'(L));
    chk("rst spurious", 64'(spurious_resp_err), 64'(L));
    next_cycle();
    rst = 1'b0;

    // m0v m0pd m1v m1pd crdy rv rpd qn | m0r m1r cv cpd r0v r1v qa qd se
    // STOP -> RUN
    tv.push_back(mk(H,rd(0),L,NOPD,H,L,NORS,H, L,L,L,NOPD,L,L,L,L,L));
    // continuous reads from both masters, responses two cycles later
    tv.push_back(mk(H,rd(0),H,rd(1),H,L,NORS,H, H,L,H,rd(0),L,L,H,L,L));
    tv.push_back(mk(H,rd(2),H,rd(1),H,L,NORS,H, L,H,H,rd(1),L,L,H,L,L));
    tv.push_back(mk(H,rd(2),H,rd(3),H,H,rp(0),H, H,L,H,rd(2),H,L,H,L,L));
    tv.push_back(mk(H,rd(4),H,rd(3),H,H,rp(1),H, L,H,H,rd(3),L,H,H,L,L));
    tv.push_back(mk(H,rd(4),H,rd(5),H,H,rp(2),H, H,L,H,rd(4),H,L,H,L,L));
    tv.push_back(mk(L,NOPD,H,rd(5),H,H,rp(3),H, L,H,H,rd(5),L,H,H,L,L));
    tv.push_back(mk(L,NOPD,L,NOPD,H,H,rp(4),H, L,L,L,NOPD,H,L,H,L,L));
    tv.push_back(mk(L,NOPD,L,NOPD,H,H,rp(5),H, L,L,L,NOPD,L,H,H,L,L));
    // fill the owner FIFO with four reads
    tv.push_back(mk(H,rd(6),L,NOPD,H,L,NORS,H, H,L,H,rd(6),L,L,H,L,L));
    tv.push_back(mk(H,rd(7),L,NOPD,H,L,NORS,H, H,L,H,rd(7),L,L,H,L,L));
    tv.push_back(mk(H,rd(8),L,NOPD,H,L,NORS,H, H,L,H,rd(8),L,L,H,L,L));
    tv.push_back(mk(H,rd(9),L,NOPD,H,L,NORS,H, H,L,H,rd(9),L,L,H,L,L));
    // full: read stalls, posted write passes, one response frees one slot
    tv.push_back(mk(H,rd(10),L,NOPD,H,L,NORS,H, L,L,L,NOPD,L,L,H,L,L));
    tv.push_back(mk(H,rd(10),H,pw(0),H,L,NORS,H, L,H,H,pw(0),L,L,H,L,L));
    tv.push_back(mk(H,rd(10),L,NOPD,H,H,rp(6),H, L,L,L,NOPD,H,L,H,L,L));
    tv.push_back(mk(H,rd(10),L,NOPD,H,L,NORS,H, H,L,H,rd(10),L,L,H,L,L));
    tv.push_back(mk(H,rd(11),L,NOPD,H,L,NORS,H, L,L,L,NOPD,L,L,H,L,L));
    tv.push_back(mk(L,NOPD,L,NOPD,H,H,rp(7),H, L,L,L,NOPD,H,L,H,L,L));
    tv.push_back(mk(L,NOPD,L,NOPD,H,H,rp(8),H, L,L,L,NOPD,H,L,H,L,L));
    tv.push_back(mk(L,NOPD,L,NOPD,H,H,rp(9),H, L,L,L,NOPD,H,L,H,L,L));
    tv.push_back(mk(L,NOPD,L,NOPD,H,H,rp(10),H, L,L,L,NOPD,H,L,H,L,L));
    // m1 posted write makes m1 the last grant, then m1 locks for 5 cycles
    tv.push_back(mk(L,NOPD,H,pw(1),H,L,NORS,H, L,H,H,pw(1),L,L,H,L,L));
    tv.push_back(mk(L,NOPD,H,rd(13),L,L,NORS,H, L,L,H,rd(13),L,L,H,L,L));
    tv.push_back(mk(H,rd(12),H,rd(13),L,L,NORS,H, L,L,H,rd(13),L,L,H,L,L));
    tv.push_back(mk(H,rd(12),H,rd(13),L,L,NORS,H, L,L,H,rd(13),L,L,H,L,L));
    tv.push_back(mk(H,rd(12),H,rd(13),L,L,NORS,H, L,L,H,rd(13),L,L,H,L,L));
    tv.push_back(mk(H,rd(12),H,rd(13),L,L,NORS,H, L,L,H,rd(13),L,L,H,L,L));
    tv.push_back(mk(H,rd(12),H,rd(13),H,L,NORS,H, L,H,H,rd(13),L,L,H,L,L));
    tv.push_back(mk(H,rd(12),H,rd(14),H,L,NORS,H, H,L,H,rd(12),L,L,H,L,L));
    tv.push_back(mk(L,NOPD,L,NOPD,H,H,rp(11),H, L,L,L,NOPD,L,H,H,L,L));
    tv.push_back(mk(L,NOPD,L,NOPD,H,H,rp(12),H, L,L,L,NOPD,H,L,H,L,L));
    // two outstanding reads, then drain to STOP and back to RUN
    tv.push_back(mk(H,rd(15),H,rd(16),H,L,NORS,H, L,H,H,rd(16),L,L,H,L,L));
    tv.push_back(mk(H,rd(15),L,NOPD,H,L,NORS,H, H,L,H,rd(15),L,L,H,L,L));
    tv.push_back(mk(L,NOPD,L,NOPD,H,L,NORS,L, L,L,L,NOPD,L,L,H,L,L));
    tv.push_back(mk(H,rd(17),L,NOPD,H,L,NORS,L, L,L,L,NOPD,L,L,H,L,L));
    tv.push_back(mk(H,rd(17),L,NOPD,H,H,rp(13),L, L,L,L,NOPD,L,H,H,L,L));
    tv.push_back(mk(H,rd(17),L,NOPD,H,H,rp(14),L, L,L,L,NOPD,H,L,H,L,L));
    tv.push_back(mk(H,rd(17),L,NOPD,H,L,NORS,L, L,L,L,NOPD,L,L,L,L,L));
    tv.push_back(mk(H,rd(17),L,NOPD,H,L,NORS,H, L,L,L,NOPD,L,L,L,L,L));
    tv.push_back(mk(H,rd(17),L,NOPD,H,L,NORS,H, H,L,H,rd(17),L,L,H,L,L));
    // unanswered read: 8 DRAIN cycles then DENY, qreqn=1 returns to RUN
    tv.push_back(mk(L,NOPD,L,NOPD,H,L,NORS,L, L,L,L,NOPD,L,L,H,L,L));
    for (int k = 0; k < 8; k++)
      tv.push_back(mk(H,rd(18),L,NOPD,H,L,NORS,L, L,L,L,NOPD,L,L,H,L,L));
    tv.push_back(mk(L,NOPD,L,NOPD,H,L,NORS,L, L,L,L,NOPD,L,L,H,H,L));
    tv.push_back(mk(L,NOPD,L,NOPD,H,L,NORS,H, L,L,L,NOPD,L,L,H,H,L));
    tv.push_back(mk(L,NOPD,L,NOPD,H,H,rp(15),H, L,L,L,NOPD,H,L,H,L,L));
    // response with nothing outstanding
    tv.push_back(mk(L,NOPD,L,NOPD,H,H,rp(16),H, L,L,L,NOPD,L,L,H,L,L));
    tv.push_back(mk(L,NOPD,L,NOPD,H,L,NORS,H, L,L,L,NOPD,L,L,H,L,H));
    tv.push_back(mk(H,rd(18),L,NOPD,H,L,NORS,H, H,L,H,rd(18),L,L,H,L,H));

    foreach (tv[i]) begin
      m0_req_pvld         = tv[i].m0v;
      m0_req_pd           = tv[i].m0pd;
      m1_req_pvld         = tv[i].m1v;
      m1_req_pd           = tv[i].m1pd;
      arb2cacc_req_prdy   = tv[i].crdy;
      cacc2arb_resp_valid = tv[i].rv;
      cacc2arb_resp_pd    = tv[i].rpd;
      qreqn               = tv[i].qn;
      #3;
      chk($sformatf("v%0d m0_prdy", i), 64'(m0_req_prdy), 64'(tv[i].m0r));
      chk($sformatf("v%0d m1_prdy", i), 64'(m1_req_prdy), 64'(tv[i].m1r));
      chk($sformatf("v%0d cacc_pvld", i), 64'(arb2cacc_req_pvld), 64'(tv[i].cv));
      chk($sformatf("v%0d cacc_pd", i), 64'(arb2cacc_req_pd), 64'(tv[i].cpd));
      chk($sformatf("v%0d m0_rvld", i), 64'(m0_resp_valid), 64'(tv[i].r0v));
      chk($sformatf("v%0d m1_rvld", i), 64'(m1_resp_valid), 64'(tv[i].r1v));
      chk($sformatf("v%0d m0_rpd", i), 64'(m0_resp_pd), 64'(tv[i].r0v ? tv[i].rpd : NORS));
      chk($sformatf("v%0d m1_rpd", i), 64'(m1_resp_pd), 64'(tv[i].r1v ? tv[i].rpd : NORS));
      chk($sformatf("v%0d qacceptn", i), 64'(qacceptn), 64'(tv[i].qa));
      chk($sformatf("v%0d qdeny", i), 64'(qdeny), 64'(tv[i].qd));
      chk($sformatf("v%0d spurious", i), 64'(spurious_resp_err), 64'(tv[i].se));
      next_cycle();
    end

    // ---- reset with one read outstanding: owner is discarded
    m0_req_pvld = 1'b1; m0_req_pd = rd(19);
    m1_req_pvld = 1'b0;
    cacc2arb_resp_valid = 1'b0;
    qreqn = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid-rst cacc_pvld", 64'(arb2cacc_req_pvld), 64'(L));
    chk("mid-rst m0_prdy", 64'(m0_req_prdy), 64'(L));
    chk("mid-rst qacceptn", 64'(qacceptn), 64'(L));
    chk("mid-rst spurious", 64'(spurious_resp_err), 64'(L));
    next_cycle();
    rst = 1'b0;
    m0_req_pvld = 1'b0;
    #3;
    chk("post-rst qacceptn", 64'(qacceptn), 64'(L));
    next_cycle();
    cacc2arb_resp_valid = 1'b1; cacc2arb_resp_pd = rp(17);
    #3;
    chk("post-rst m0_rvld", 64'(m0_resp_valid), 64'(L));
    chk("post-rst m1_rvld", 64'(m1_resp_valid), 64'(L));
    chk("post-rst qacceptn run", 64'(qacceptn), 64'(H));
    next_cycle();
    cacc2arb_resp_valid = 1'b0;
    #3;
    chk("post-rst spurious", 64'(spurious_resp_err), 64'(H));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_cacc_csb_arb.md
NV_NVDLA_CACC_CSB_ARB -- requirements
Module: nv_nvdla_cacc_csb_arb

Interface
REQ-001 SHALL have parameter OWN_DEPTH, default 4, meaning the number of response-owner FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter DRAIN_TMO, default 64, meaning the drain-timeout limit in cycles (1..255).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: nvdla_core_clk in 1, the clock; nvdla_core_rst in 1, the reset.
REQ-004 SHALL have m0_req_pvld in 1 and m1_req_pvld in 1: host / auxiliary CSB request valid.
REQ-005 SHALL have m0_req_prdy out 1 and m1_req_prdy out 1: request accepted.
REQ-006 SHALL have m0_req_pd in 63 and m1_req_pd in 63: CSB request; bit54=write, bit55=nposted.
REQ-007 SHALL have arb2cacc_req_pvld out 1, arb2cacc_req_prdy in 1 and arb2cacc_req_pd out 63: the shared cacc CSB request port.
REQ-008 SHALL have cacc2arb_resp_valid in 1 and cacc2arb_resp_pd in 34: the cacc response.
REQ-009 SHALL have m0_resp_valid out 1, m0_resp_pd out 34, m1_resp_valid out 1 and m1_resp_pd out 34: the routed responses.
REQ-010 SHALL have qreqn in 1, qacceptn out 1 and qdeny out 1: the Q-channel.
REQ-011 SHALL have spurious_resp_err out 1: sticky flag for a response arriving with no owner.

Function
REQ-012 A request SHALL expect a response when bit54=0 (read) or bit55=1 (non-posted write); posted writes expect none.
REQ-013 A master SHALL be eligible when its pvld=1, Q state is RUN, and either (owner FIFO not full) or (its request expects no response).
REQ-014 Arbitration SHALL be round-robin: registered last_grant pointer (reset 1) favours the other master when both are eligible.
REQ-015 Grant SHALL lock (lock register) while arb2cacc_req_pvld=1 and arb2cacc_req_prdy=0; pd and selection are held until the handshake.
REQ-016 arb2cacc_req_pvld SHALL be the granted master's pvld and arb2cacc_req_pd its pd; the granted mX_req_prdy equals arb2cacc_req_prdy and the other prdy is 0; zero added latency.
REQ-017 On a handshake, last_grant SHALL update to the granted master and the lock SHALL clear.
REQ-018 On a handshake of a response-expecting request, the owner id SHALL push into the FIFO.
REQ-019 On cacc2arb_resp_valid=1 with the FIFO non-empty, the head SHALL pop, and the pd SHALL route combinationally to the owner's resp port for that cycle only; the other resp_valid stays 0.
REQ-020 Simultaneous push and pop SHALL keep the count unchanged; push when full SHALL be impossible by REQ-013.
REQ-021 A response arriving with the FIFO empty SHALL be dropped and set spurious_resp_err=1 until reset.
REQ-022 Q FSM states SHALL be STOP, RUN, DRAIN and DENY.
REQ-023 STOP -> RUN SHALL occur when qreqn=1.
REQ-024 RUN -> DRAIN SHALL occur when qreqn=0 and lock=0; a locked grant completes first.
REQ-025 In DRAIN, no new grants SHALL be issued and drain_cnt increments each cycle.
REQ-026 DRAIN exits SHALL be checked in this priority order: qreqn=1 -> RUN; then FIFO empty -> STOP; then drain_cnt=DRAIN_TMO-1 -> DENY.
REQ-027 In DENY, qdeny SHALL be 1; DENY -> RUN when qreqn=1.
REQ-028 drain_cnt SHALL clear on every entry to DRAIN.
REQ-029 qacceptn SHALL be 0 only in STOP; qdeny SHALL be 1 only in DENY; both are registered state decodes.
REQ-030 Responses SHALL still route in DRAIN, DENY and STOP.

Reset
REQ-031 Assertion of nvdla_core_rst SHALL immediately force: state=STOP, lock=0, last_grant=1, FIFO empty, drain_cnt=0, spurious_resp_err=0.
REQ-032 During and after reset, until the first qreqn=1 cycle completes: all prdy=0, arb2cacc_req_pvld=0, qacceptn=0, qdeny=0.
REQ-033 Reset mid-transaction SHALL discard outstanding owners; later responses set spurious_resp_err.

Verification
REQ-034 Both masters issue continuous reads, cacc_prdy=1, resp after 2 cycles -> grants alternate m0,m1,m0...; each response reaches the issuer in order.
REQ-035 OWN_DEPTH=4, 4 outstanding reads, no responses -> reads stall with prdy=0; a posted write (bit54=1, bit55=0) still passes; one response unblocks one read.
REQ-036 m1 held with cacc_prdy=0 for 5 cycles while m0 requests -> pd stable and m1 still granted; then m0 is granted next.
REQ-037 qreqn falls with 2 outstanding reads -> DRAIN; both responses return -> qacceptn=0 on the following cycle; qreqn=1 -> RUN.
REQ-038 DRAIN_TMO=8, one read never answered -> qdeny=1 after 8 DRAIN cycles; qreqn=1 -> qdeny=0, RUN.
REQ-039 Response with no outstanding request -> dropped, no resp_valid, spurious_resp_err=1 until reset.
